// File: rtl/lab2_bcd_to_excess3_serial.sv
// Bit-serial BCD-to-Excess-3 encoder: adds 3 with a one-bit serial adder and streams the code
// LSB first with a per-digit last marker. Define LAB2_ODD_PARITY_EN to append an odd-parity bit.
module lab2_bcd_to_excess3_serial (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] in_digit_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    output logic       ser_out_o,
    output logic       ser_valid_o,
    output logic       ser_last_o,
    output logic       err_o,
    output logic [7:0] digit_cnt_o
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StPar
    } state_e;

`ifdef LAB2_ODD_PARITY_EN
    localparam logic HasParity = 1'b1;
`else
    localparam logic HasParity = 1'b0;
`endif

    state_e     state_q;
    logic [1:0] idx_q;
    logic [3:0] digit_q;
    logic       carry_q;
    logic       ser_out_q;
    logic       ser_valid_q;
    logic       ser_last_q;
    logic       err_q;
    logic [7:0] cnt_q;
`ifdef LAB2_ODD_PARITY_EN
    logic       par_q;
`endif

    logic       accept;
    logic       digit_ok;
    logic       first_bit;
    logic       first_carry;
    logic [1:0] next_idx;
    logic       k_bit;
    logic       d_bit;
    logic       sum_bit;
    logic       sum_carry;

    always_comb begin
`ifdef LAB2_ODD_PARITY_EN
        in_ready_o = (state_q == StIdle) || (state_q == StPar);
`else
        in_ready_o = (state_q == StIdle) || ((state_q == StShift) && (idx_q == 2'd3));
`endif
    end

    always_comb begin
        accept      = in_valid_i && in_ready_o;
        digit_ok    = (in_digit_i <= 4'd9);
        // Bit 0 of K is 1 and the carry starts at 0, so the first sum/carry are trivial.
        first_bit   = ~in_digit_i[0];
        first_carry = in_digit_i[0];
        next_idx    = idx_q + 2'd1;
        k_bit       = (next_idx == 2'd1);
        d_bit       = digit_q[next_idx];
        sum_bit     = d_bit ^ k_bit ^ carry_q;
        sum_carry   = (d_bit & k_bit) | (d_bit & carry_q) | (k_bit & carry_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            idx_q       <= 2'd0;
            digit_q     <= 4'd0;
            carry_q     <= 1'b0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= 8'd0;
`ifdef LAB2_ODD_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            err_q <= accept && !digit_ok;
            if (ser_last_q) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (accept && digit_ok) begin
                state_q     <= StShift;
                idx_q       <= 2'd0;
                digit_q     <= in_digit_i;
                carry_q     <= first_carry;
                ser_out_q   <= first_bit;
                ser_valid_q <= 1'b1;
                ser_last_q  <= 1'b0;
`ifdef LAB2_ODD_PARITY_EN
                par_q       <= first_bit;
`endif
            end else if (accept) begin
                // Rejected digit: no frame, even if it arrived on a last-bit cycle.
                state_q     <= StIdle;
                ser_out_q   <= 1'b0;
                ser_valid_q <= 1'b0;
                ser_last_q  <= 1'b0;
            end else begin
                case (state_q)
                    StShift: begin
                        if (idx_q != 2'd3) begin
                            idx_q       <= next_idx;
                            carry_q     <= sum_carry;
                            ser_out_q   <= sum_bit;
                            ser_valid_q <= 1'b1;
                            ser_last_q  <= (next_idx == 2'd3) && !HasParity;
`ifdef LAB2_ODD_PARITY_EN
                            par_q       <= par_q ^ sum_bit;
`endif
                        end else begin
`ifdef LAB2_ODD_PARITY_EN
                            state_q     <= StPar;
                            ser_out_q   <= ~par_q;
                            ser_valid_q <= 1'b1;
                            ser_last_q  <= 1'b1;
`else
                            state_q     <= StIdle;
                            ser_out_q   <= 1'b0;
                            ser_valid_q <= 1'b0;
                            ser_last_q  <= 1'b0;
`endif
                        end
                    end
                    default: begin
                        state_q     <= StIdle;
                        ser_out_q   <= 1'b0;
                        ser_valid_q <= 1'b0;
                        ser_last_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ser_out_o   = ser_out_q;
    assign ser_valid_o = ser_valid_q;
    assign ser_last_o  = ser_last_q;
    assign err_o       = err_q;
    assign digit_cnt_o = cnt_q;

endmodule

// File: tb/tb_lab2_bcd_to_excess3_serial.sv
// Randomized self-checking bench for lab2_bcd_to_excess3_serial against an arithmetic
// Excess-3 model (code = digit + 3, optional odd parity under LAB2_ODD_PARITY_EN).
module tb_lab2_bcd_to_excess3_serial;

`ifdef LAB2_ODD_PARITY_EN
    localparam int F = 5;
`else
    localparam int F = 4;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_digit;
    logic       in_valid;
    logic       in_ready;
    logic       ser_out;
    logic       ser_valid;
    logic       ser_last;
    logic       err;
    logic [7:0] digit_cnt;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    lab2_bcd_to_excess3_serial dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_digit_i (in_digit),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .ser_out_o  (ser_out),
        .ser_valid_o(ser_valid),
        .ser_last_o (ser_last),
        .err_o      (err),
        .digit_cnt_o(digit_cnt)
    );

    // Bit i of the frame for digit d: Excess-3 code bits LSB first, then odd parity.
    function automatic logic exp_bit(input int d, input int i);
        logic [3:0] code;
        code = 4'(d + 3);
        if (i < 4) return code[i];
        return ~^code;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_digit = 4'd0;
        repeat (3) @(negedge clk);
        total++;
        if ({in_ready, ser_out, ser_valid, ser_last, err, digit_cnt} !== {1'b1, 4'b0, 8'd0}) begin
            bad++;
            $display("FAIL reset_state got rdy=%b out=%b vld=%b last=%b err=%b cnt=%0d want 1 0 0 0 0 0",
                     in_ready, ser_out, ser_valid, ser_last, err, digit_cnt);
        end
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_digit_table();
        for (int n = 0; n < 26; n++) begin
            int d;
            d = (n < 10) ? n : int'($urandom_range(9));
            @(negedge clk);
            in_digit = 4'(d);
            in_valid = 1'b1;
            for (int i = 0; i < F; i++) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_digit = 4'($urandom_range(15));
                total++;
                if (ser_valid !== 1'b1 || ser_out !== exp_bit(d, i) || ser_last !== (i == F - 1)) begin
                    bad++;
                    $display("FAIL digit_bit d=%0d i=%0d got vld=%b out=%b last=%b want 1 %b %b",
                             d, i, ser_valid, ser_out, ser_last, exp_bit(d, i), i == F - 1);
                end
            end
            @(negedge clk);
            exp_cnt = (exp_cnt + 1) % 256;
            total++;
            if (ser_valid !== 1'b0 || digit_cnt !== 8'(exp_cnt) || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL digit_end d=%0d got vld=%b cnt=%0d rdy=%b want 0 %0d 1",
                         d, ser_valid, digit_cnt, in_ready, exp_cnt);
            end
        end
    endtask

    task automatic test_error();
        int d;
        int g;
        // Rejected digit from idle.
        @(negedge clk);
        d = $urandom_range(15, 10);
        in_digit = 4'(d);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (err !== 1'b1 || ser_valid !== 1'b0 || in_ready !== 1'b1 || digit_cnt !== 8'(exp_cnt)) begin
            bad++;
            $display("FAIL err_idle d=%0d got err=%b vld=%b rdy=%b cnt=%0d want 1 0 1 %0d",
                     d, err, ser_valid, in_ready, digit_cnt, exp_cnt);
        end
        @(negedge clk);
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL err_pulse_width got err=%b want 0", err);
        end
        // Rejected digit accepted on the last-bit cycle of a good frame.
        g = $urandom_range(9);
        in_digit = 4'(g);
        in_valid = 1'b1;
        for (int i = 0; i < F; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            total++;
            if (ser_valid !== 1'b1 || ser_out !== exp_bit(g, i)) begin
                bad++;
                $display("FAIL err_frame_bit d=%0d i=%0d got vld=%b out=%b want 1 %b",
                         g, i, ser_valid, ser_out, exp_bit(g, i));
            end
        end
        d = $urandom_range(15, 10);
        in_digit = 4'(d);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        exp_cnt = (exp_cnt + 1) % 256;
        total++;
        if (err !== 1'b1 || ser_valid !== 1'b0 || ser_last !== 1'b0 || digit_cnt !== 8'(exp_cnt)) begin
            bad++;
            $display("FAIL err_on_last d=%0d got err=%b vld=%b last=%b cnt=%0d want 1 0 0 %0d",
                     d, err, ser_valid, ser_last, digit_cnt, exp_cnt);
        end
        @(negedge clk);
        total++;
        if (err !== 1'b0 || ser_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL err_after_last got err=%b vld=%b rdy=%b want 0 0 1", err, ser_valid, in_ready);
        end
    endtask

    // Digits streamed with in_valid held; the next digit is presented exactly when ready.
    task automatic test_back_to_back(input int n, input bit fixed_head);
        int digits[$];
        int base;
        base = exp_cnt;
        for (int j = 0; j < n; j++) begin
            if (fixed_head && j == 0) digits.push_back(5);
            else if (fixed_head && j == 1) digits.push_back(7);
            else digits.push_back(int'($urandom_range(9)));
        end
        for (int c = 0; c <= n * F + 1; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                int k;
                k = c - 1;
                total++;
                if (k < n * F) begin
                    if (ser_valid !== 1'b1 || ser_out !== exp_bit(digits[k / F], k % F) ||
                        ser_last !== (k % F == F - 1) || in_ready !== (c % F == 0) ||
                        digit_cnt !== 8'((base + (c - 1) / F) % 256)) begin
                        bad++;
                        $display("FAIL b2b_bit k=%0d got vld=%b out=%b last=%b rdy=%b cnt=%0d want 1 %b %b %b %0d",
                                 k, ser_valid, ser_out, ser_last, in_ready, digit_cnt,
                                 exp_bit(digits[k / F], k % F), k % F == F - 1, c % F == 0,
                                 (base + (c - 1) / F) % 256);
                    end
                end else begin
                    if (ser_valid !== 1'b0 || digit_cnt !== 8'((base + n) % 256)) begin
                        bad++;
                        $display("FAIL b2b_end got vld=%b cnt=%0d want 0 %0d",
                                 ser_valid, digit_cnt, (base + n) % 256);
                    end
                end
            end
            if (c % F == 0 && c / F < n) begin
                in_valid = 1'b1;
                in_digit = 4'(digits[c / F]);
            end else if (c >= n * F) begin
                in_valid = 1'b0;
            end else begin
                in_digit = 4'($urandom_range(15));
            end
        end
        exp_cnt = (base + n) % 256;
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        in_digit = 4'd4;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (ser_valid !== 1'b1 || ser_out !== exp_bit(4, 2)) begin
            bad++;
            $display("FAIL mid_bit2 got vld=%b out=%b want 1 %b", ser_valid, ser_out, exp_bit(4, 2));
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({in_ready, ser_out, ser_valid, ser_last, err, digit_cnt} !== {1'b1, 4'b0, 8'd0}) begin
            bad++;
            $display("FAIL mid_reset got rdy=%b out=%b vld=%b last=%b err=%b cnt=%0d want 1 0 0 0 0 0",
                     in_ready, ser_out, ser_valid, ser_last, err, digit_cnt);
        end
        rst = 1'b0;
        exp_cnt = 0;
        in_digit = 4'd3;
        in_valid = 1'b1;
        for (int i = 0; i < F; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            total++;
            if (ser_valid !== 1'b1 || ser_out !== exp_bit(3, i) || ser_last !== (i == F - 1)) begin
                bad++;
                $display("FAIL post_reset_bit i=%0d got vld=%b out=%b last=%b want 1 %b %b",
                         i, ser_valid, ser_out, ser_last, exp_bit(3, i), i == F - 1);
            end
        end
        @(negedge clk);
        exp_cnt = 1;
        total++;
        if (digit_cnt !== 8'd1 || ser_valid !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_cnt got cnt=%0d vld=%b want 1 0", digit_cnt, ser_valid);
        end
    endtask

    initial begin
        test_reset();
        test_digit_table();
        test_error();
        test_back_to_back(6, 1'b1);
        test_reset_mid_frame();
        test_back_to_back(256, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
